// File: rtl/exmem_skid_reg.sv
// EX/MEM pipeline register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a saturating stall counter. Bubbles always carry ctrl=0.
module exmem_skid_reg #(
    parameter int CTRL_W = 7,
    parameter int DATA_W = 102,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Handshake: a beat moves on any edge where valid and ready are both high;
    // ready never depends on the opposite side's ready in the same cycle.
    // State encoding doubles as the entry count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_stalled;

    assign in_ready   = (r_state != S_TWO) && !rst;
    assign out_valid  = (r_state != S_EMPTY);
    assign out_ctrl   = r_main_ctrl;
    assign out_data   = r_main_data;
    assign occupancy  = r_state;
    assign stall_cnt  = r_stall_cnt;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_stalled  = out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
            r_stall_cnt <= '0;
        end else begin
            // Counter ignores flush so stall statistics survive squashes.
            if (w_stalled && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (flush) begin
                r_state     <= S_EMPTY;
                r_main_ctrl <= '0;
                r_skid_ctrl <= '0;
            end else begin
                case (r_state)
                    S_EMPTY: begin
                        if (w_in_fire) begin
                            r_main_ctrl <= in_ctrl;
                            r_main_data <= in_data;
                            r_state     <= S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (w_in_fire && w_out_fire) begin
                            r_main_ctrl <= in_ctrl;
                            r_main_data <= in_data;
                        end else if (w_in_fire) begin
                            r_skid_ctrl <= in_ctrl;
                            r_skid_data <= in_data;
                            r_state     <= S_TWO;
                        end else if (w_out_fire) begin
                            r_main_ctrl <= '0;
                            r_state     <= S_EMPTY;
                        end
                    end
                    S_TWO: begin
                        if (out_ready) begin
                            r_main_ctrl <= r_skid_ctrl;
                            r_main_data <= r_skid_data;
                            r_skid_ctrl <= '0;
                            r_state     <= S_ONE;
                        end
                    end
                    default: begin
                        r_state     <= S_EMPTY;
                        r_main_ctrl <= '0;
                        r_skid_ctrl <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exmem_skid_reg.sv
// Bench for exmem_skid_reg: directed scenarios plus a random phase, with a
// FIFO scoreboard of expected {ctrl,data} beats checked on every delivery.
module tb_exmem_skid_reg;

    localparam int CTRL_W = 7;
    localparam int DATA_W = 102;
    localparam int CNT_W  = 16;
    localparam int W      = CTRL_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    // Narrow-counter instance shares all inputs; only its counter is checked.
    logic              s_in_ready;
    logic              s_out_valid;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [DATA_W-1:0] s_out_data;
    logic [1:0]        s_occupancy;
    logic [2:0]        s_stall_cnt;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    exmem_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    exmem_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                          input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Scoreboard: inputs change only just after posedge, so the negedge view
    // is exactly what the next edge will act on.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 128'(1), 128'(0));
                end else begin
                    check("sb_beat", 128'({out_ctrl, out_data}), 128'(exp_q.pop_front()));
                end
            end
            if (!out_valid) begin
                check("bubble_ctrl", 128'(out_ctrl), 128'(0));
            end
        end
        if (rst || flush) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back({in_ctrl, in_data});
        end
    end

    initial begin
        logic [127:0] rnd;
        rst = 1'b1;
        set_in(1'b1, 7'h7F, '1, 1'b1, 1'b0);

        // Reset held two cycles with a beat offered
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_out_valid", 128'(out_valid), 128'(0));
            check("rst_out_ctrl", 128'(out_ctrl), 128'(0));
            check("rst_out_data", 128'(out_data), 128'(0));
            check("rst_occ", 128'(occupancy), 128'(0));
            check("rst_stall", 128'(stall_cnt), 128'(0));
            check("rst_in_ready", 128'(in_ready), 128'(0));
        end
        rst = 1'b0;
        set_in(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        check("post_rst_in_ready", 128'(in_ready), 128'(1));
        check("post_rst_out_valid", 128'(out_valid), 128'(0));

        // Streaming at one beat per cycle
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, CTRL_W'(7'h10 + i), DATA_W'(i), 1'b1, 1'b0);
            tick();
            check("stream_ctrl", 128'(out_ctrl), 128'(7'h10 + i));
            check("stream_data", 128'(out_data), 128'(i));
            check("stream_occ", 128'(occupancy), 128'(1));
        end
        set_in(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        check("drain_valid", 128'(out_valid), 128'(0));
        check("drain_ctrl", 128'(out_ctrl), 128'(0));
        check("drain_data_held", 128'(out_data), 128'(3));
        check("drain_occ", 128'(occupancy), 128'(0));

        // Skid fill and drain
        set_in(1'b1, 7'h21, DATA_W'(10), 1'b1, 1'b0);
        tick();
        set_in(1'b1, 7'h22, DATA_W'(11), 1'b0, 1'b0);
        tick();
        check("skid_occ", 128'(occupancy), 128'(2));
        check("skid_in_ready", 128'(in_ready), 128'(0));
        check("skid_out_data", 128'(out_data), 128'(10));
        check("skid_out_ctrl", 128'(out_ctrl), 128'(7'h21));
        set_in(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        check("skid_b_data", 128'(out_data), 128'(11));
        check("skid_b_ctrl", 128'(out_ctrl), 128'(7'h22));
        check("skid_in_ready_back", 128'(in_ready), 128'(1));
        tick();
        check("skid_empty", 128'(occupancy), 128'(0));

        // Flush while in TWO with a new beat offered
        set_in(1'b1, 7'h31, DATA_W'(20), 1'b1, 1'b0);
        tick();
        set_in(1'b1, 7'h32, DATA_W'(21), 1'b0, 1'b0);
        tick();
        check("pre_flush_occ", 128'(occupancy), 128'(2));
        set_in(1'b1, 7'h33, DATA_W'(22), 1'b0, 1'b1);
        tick();
        check("flush_valid", 128'(out_valid), 128'(0));
        check("flush_ctrl", 128'(out_ctrl), 128'(0));
        check("flush_occ", 128'(occupancy), 128'(0));
        check("flush_in_ready", 128'(in_ready), 128'(1));
        set_in(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_c", 128'(out_valid), 128'(0));
        end

        // Stall counter: 5 stalled cycles, then flush with a delivery
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("cnt_zero", 128'(stall_cnt), 128'(0));
        set_in(1'b1, 7'h41, DATA_W'(30), 1'b0, 1'b0);
        tick();
        set_in(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (5) tick();
        check("cnt_five", 128'(stall_cnt), 128'(5));
        set_in(1'b0, '0, '0, 1'b1, 1'b1);
        tick();
        check("cnt_after_flush", 128'(stall_cnt), 128'(5));
        check("cnt_flush_occ", 128'(occupancy), 128'(0));

        // Saturation with the 3-bit instance
        rst = 1'b1;
        set_in(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        set_in(1'b1, 7'h51, DATA_W'(40), 1'b0, 1'b0);
        tick();
        set_in(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (10) tick();
        check("cnt_sat_small", 128'(s_stall_cnt), 128'(7));
        check("cnt_wide_ten", 128'(stall_cnt), 128'(10));
        set_in(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        check("sat_drain_occ", 128'(occupancy), 128'(0));

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            set_in(1'($urandom_range(0, 3) != 0), CTRL_W'($urandom_range(1, 127)),
                   rnd[DATA_W-1:0], 1'($urandom_range(0, 2) != 0),
                   1'($urandom_range(0, 40) == 0));
            tick();
        end

        // Bounded drain; everything accepted must have come out
        set_in(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 10 && out_valid; i++) begin
            tick();
        end
        tick();
        check("final_occ", 128'(occupancy), 128'(0));
        check("final_queue", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
